// File: rtl/console_pkg.sv
// Shared constants, state and command encodings for the text console controller.
package console_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 60;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 6;
    localparam int unsigned CHAR_W = 7;

    localparam logic [CHAR_W-1:0] BLANK = 7'h20;
    localparam logic [CHAR_W-1:0] LF    = 7'h0A;
    localparam logic [CHAR_W-1:0] CR    = 7'h0D;
    localparam logic [CHAR_W-1:0] BS    = 7'h08;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_NL,
        CUR_CR,
        CUR_BS
    } cur_cmd_t;

    // True for codes that are written to the screen verbatim.
    function automatic logic is_printable(input logic [CHAR_W-1:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor/scroll bookkeeping: row, column, scroll row and the linear cursor address,
// kept incrementally via a row-base register so no multiplier is needed.
module console_cursor
    import console_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [2:0]        cmd,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  scroll_row,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic [ADDR_W-1:0] next_base_c,
    output logic              col_last_c,
    output logic              wrap_c
);

    cur_cmd_t          cmd_e;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic [ROW_W-1:0]  next_row_c;
    logic [ROW_W-1:0]  next_scroll_c;
    logic              newline_c;

    assign cmd_e = cur_cmd_t'(cmd);

    // Modulo-ROWS successors and the scroll / end-of-line conditions.
    always_comb begin
        next_row_c    = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
        next_scroll_c = (scroll_row == ROW_W'(ROWS - 1)) ? '0 : scroll_row + ROW_W'(1);
        next_base_c   = (row_base == ADDR_W'(CELLS - COLS)) ? '0 : row_base + ADDR_W'(COLS);
        col_last_c    = (col == COL_W'(COLS - 1));
        wrap_c        = (next_row_c == scroll_row);
        newline_c     = (cmd_e == CUR_NL) || ((cmd_e == CUR_ADV) && col_last_c);
    end

    // Apply the cursor command; a newline onto the top row also advances the scroll row.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            row_base    <= '0;
            scroll_row  <= '0;
            cursor_addr <= '0;
        end else if (newline_c) begin
            col         <= '0;
            row         <= next_row_c;
            row_base    <= next_base_c;
            cursor_addr <= next_base_c;
            if (wrap_c) begin
                scroll_row <= next_scroll_c;
            end
        end else begin
            case (cmd_e)
                CUR_ADV: begin
                    col         <= col + COL_W'(1);
                    cursor_addr <= cursor_addr + ADDR_W'(1);
                end
                CUR_CR: begin
                    col         <= '0;
                    cursor_addr <= row_base;
                end
                CUR_BS: begin
                    if (col != '0) begin
                        col         <= col - COL_W'(1);
                        cursor_addr <= cursor_addr - ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Character-stream controller: screen init, control-code handling, scroll-and-clear,
// and the registered VRAM write port.
module text_console_ctrl
    import console_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              ch_valid,
    input  logic [6:0]        ch_data,
    output logic              ch_ready,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [6:0]        vram_data,
    output logic [5:0]        scroll_row,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [6:0]        data_d;
    logic              ready_d;
    cur_cmd_t          cmd_c;
    logic              accept_c;

    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] next_base_c;
    logic              col_last_c;
    logic              wrap_c;

    console_cursor u_cursor (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .cmd         (cmd_c),
        .col         (col),
        .scroll_row  (scroll_row),
        .cursor_addr (cursor_addr),
        .next_base_c (next_base_c),
        .col_last_c  (col_last_c),
        .wrap_c      (wrap_c)
    );

    // Next-state, write-port and handshake decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_addr_d = clr_addr_q;
        we_d       = 1'b0;
        addr_d     = vram_addr;
        data_d     = vram_data;
        ready_d    = 1'b0;
        cmd_c      = CUR_NONE;
        accept_c   = ch_valid && ch_ready;

        case (state_q)
            INIT: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = BLANK;
                if (cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    if (is_printable(ch_data)) begin
                        cmd_c  = CUR_ADV;
                        we_d   = 1'b1;
                        addr_d = cursor_addr;
                        data_d = ch_data;
                        // Own write goes out now; all 80 clear writes follow.
                        if (col_last_c && wrap_c) begin
                            state_d    = CLEAR;
                            ready_d    = 1'b0;
                            clr_addr_d = next_base_c;
                            cnt_d      = '0;
                        end
                    end else if (ch_data == LF) begin
                        cmd_c = CUR_NL;
                        // LF has no own write, so the first clear write goes out now.
                        if (wrap_c) begin
                            state_d    = CLEAR;
                            ready_d    = 1'b0;
                            we_d       = 1'b1;
                            addr_d     = next_base_c;
                            data_d     = BLANK;
                            clr_addr_d = next_base_c + ADDR_W'(1);
                            cnt_d      = ADDR_W'(1);
                        end
                    end else if (ch_data == CR) begin
                        cmd_c = CUR_CR;
                    end else if ((ch_data == BS) && (col != '0)) begin
                        cmd_c  = CUR_BS;
                        we_d   = 1'b1;
                        addr_d = cursor_addr - ADDR_W'(1);
                        data_d = BLANK;
                    end
                end
            end

            CLEAR: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                data_d     = BLANK;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            clr_addr_q <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_data  <= '0;
            ch_ready   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_addr_q <= clr_addr_d;
            vram_we    <= we_d;
            vram_addr  <= addr_d;
            vram_data  <= data_d;
            ch_ready   <= ready_d;
            busy       <= !ready_d;
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a write scoreboard and a cursor model.
module tb_text_console_ctrl;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;
    localparam logic [6:0] SP   = 7'h20;
    localparam logic [6:0] C_LF = 7'h0A;
    localparam logic [6:0] C_CR = 7'h0D;
    localparam logic [6:0] C_BS = 7'h08;

    typedef struct packed {
        logic [12:0] addr;
        logic [6:0]  data;
        logic [31:0] cyc;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        ch_valid = 1'b0;
    logic [6:0]  ch_data = 7'h00;
    logic        ch_ready;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [6:0]  vram_data;
    logic [5:0]  scroll_row;
    logic [12:0] cursor_addr;
    logic        busy;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    wr_t sb[$];
    int  m_row = 0;
    int  m_col = 0;
    int  m_scroll = 0;

    text_console_ctrl dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .vram_we     (vram_we),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .scroll_row  (scroll_row),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Every VRAM write must match the oldest expected write, including its cycle.
    always @(negedge clk_sys) begin
        if (vram_we === 1'b1) begin
            wr_t obs;
            wr_t want;
            bit  none;
            obs.addr = vram_addr;
            obs.data = vram_data;
            obs.cyc  = 32'(cyc);
            none = (sb.size() == 0);
            if (none) want = '0;
            else      want = sb.pop_front();
            n_checks++;
            assert (obs === want) else begin
                n_fail++;
                $error("FAIL vram_write: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d%s",
                       obs.addr, obs.data, obs.cyc, want.addr, want.data, want.cyc,
                       none ? " (no write expected)" : "");
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    task automatic push(input int a, input logic [6:0] d, input int c);
        wr_t e;
        e.addr = 13'(a);
        e.data = d;
        e.cyc  = 32'(c);
        sb.push_back(e);
    endtask

    function automatic int m_addr();
        return m_row * COLS + m_col;
    endfunction

    function automatic bit m_newline();
        int nr;
        bit scrolled;
        scrolled = 1'b0;
        nr = (m_row + 1) % ROWS;
        if (nr == m_scroll) begin
            m_scroll = (m_scroll + 1) % ROWS;
            scrolled = 1'b1;
        end
        m_row = nr;
        m_col = 0;
        return scrolled;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_we"},     int'(vram_we), 0);
        chk({tag, "_addr"},   int'(vram_addr), 0);
        chk({tag, "_data"},   int'(vram_data), 0);
        chk({tag, "_scroll"}, int'(scroll_row), 0);
        chk({tag, "_cursor"}, int'(cursor_addr), 0);
        chk({tag, "_ready"},  int'(ch_ready), 0);
        chk({tag, "_busy"},   int'(busy), 1);
    endtask

    // Release reset (caller is just past a rising edge) and expect a full screen init.
    task automatic run_init();
        int r;
        int t;
        bit ok;
        rst = 1'b0;
        r = cyc;
        for (int i = 0; i < CELLS; i++) push(i, SP, r + 1 + i);
        ok = 1'b1;
        t = 0;
        while (ch_ready !== 1'b1 && t < CELLS + 100) begin
            if (busy !== 1'b1) ok = 1'b0;
            @(posedge clk_sys); #1;
            t++;
        end
        chk("init_busy_held", int'(ok), 1);
        chk("init_ready_cycle", cyc, r + CELLS + 1);
        chk("init_cursor", int'(cursor_addr), 0);
        chk("init_scroll", int'(scroll_row), 0);
        chk("init_busy_done", int'(busy), 0);
        m_row = 0;
        m_col = 0;
        m_scroll = 0;
    endtask

    // Offer one character, predict its effect and check cursor/scroll/handshake.
    task automatic send(input logic [6:0] c);
        int  t;
        int  tx;
        int  ready_cyc;
        bit  scrolled;
        bit  ok;
        ch_valid = 1'b1;
        ch_data  = c;
        t = 0;
        while (ch_ready !== 1'b1 && t < 300) begin
            @(posedge clk_sys); #1;
            t++;
        end
        if (ch_ready !== 1'b1) chk("ready_timeout", int'(ch_ready), 1);
        @(posedge clk_sys); #1;
        ch_valid = 1'b0;
        tx = cyc;
        scrolled = 1'b0;
        ready_cyc = tx;
        if (c >= 7'h20 && c <= 7'h7E) begin
            push(m_addr(), c, tx);
            m_col++;
            if (m_col == COLS) begin
                scrolled = m_newline();
                if (scrolled) begin
                    for (int k = 0; k < COLS; k++) push(m_row * COLS + k, SP, tx + 1 + k);
                    ready_cyc = tx + COLS + 1;
                end
            end
        end else if (c == C_LF) begin
            scrolled = m_newline();
            if (scrolled) begin
                for (int k = 0; k < COLS; k++) push(m_row * COLS + k, SP, tx + k);
                ready_cyc = tx + COLS;
            end
        end else if (c == C_CR) begin
            m_col = 0;
        end else if (c == C_BS) begin
            if (m_col > 0) begin
                m_col--;
                push(m_addr(), SP, tx);
            end
        end
        chk("cursor_addr", int'(cursor_addr), m_addr());
        chk("scroll_row", int'(scroll_row), m_scroll);
        if (scrolled) begin
            ok = 1'b1;
            while (cyc < ready_cyc) begin
                if (ch_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
                @(posedge clk_sys); #1;
            end
            chk("clear_stall", int'(ok), 1);
            chk("ready_after_clear", int'(ch_ready), 1);
            chk("busy_after_clear", int'(busy), 0);
        end else begin
            chk("ready_kept", int'(ch_ready), 1);
        end
    endtask

    initial begin
        int tx;
        logic [6:0] c;

        rst = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_values("reset");
        run_init();

        // Back-to-back printables
        send(7'h41);
        send(7'h42);
        chk("ab_cursor", int'(cursor_addr), 2);

        // CR, printable, CR, then backspace at column 0 does nothing
        send(C_CR);
        send(7'h58);
        send(C_CR);
        send(C_BS);
        send(C_BS);
        chk("bs_col0_cursor", int'(cursor_addr), 0);

        // Five characters then a backspace blanks column 4
        for (int k = 0; k < 5; k++) begin
            c = 7'(8'h61 + k);
            send(c);
        end
        send(C_BS);
        chk("bs_cursor", int'(cursor_addr), 4);

        // Non-printing, non-control codes are swallowed
        send(7'h07);
        send(7'h7F);
        send(7'h00);

        // 59 line feeds reach the last row, the 60th scrolls and clears row 0
        send(C_CR);
        for (int k = 0; k < ROWS - 1; k++) send(C_LF);
        chk("row59_cursor", int'(cursor_addr), (ROWS - 1) * COLS);
        send(C_LF);
        chk("lf_scroll_row", int'(scroll_row), 1);
        chk("lf_scroll_cursor", int'(cursor_addr), 0);

        // A full line of printables wraps at column 79 into a scroll
        for (int k = 0; k < COLS; k++) begin
            c = 7'(97 + (k % 26));
            send(c);
        end
        chk("wrap_scroll_row", int'(scroll_row), 2);
        chk("wrap_cursor", int'(cursor_addr), COLS);

        // Reset in the middle of a clear
        ch_valid = 1'b1;
        ch_data  = C_LF;
        @(posedge clk_sys); #1;
        ch_valid = 1'b0;
        tx = cyc;
        void'(m_newline());
        for (int k = 0; k < 5; k++) push(m_row * COLS + k, SP, tx + k);
        chk("midclear_scroll", int'(scroll_row), m_scroll);
        chk("midclear_ready", int'(ch_ready), 0);
        repeat (4) @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("midclear_rst");
        chk("midclear_sb_drained", sb.size(), 0);
        repeat (2) @(posedge clk_sys);
        #1;
        run_init();

        send(7'h5A);
        chk("post_reinit_cursor", int'(cursor_addr), 1);
        repeat (3) @(posedge clk_sys);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
